// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 timing generator that reads RGB332 pixels from frame RAM port B and drives a 4-bit-per-channel VGA DAC
module vga_scanout #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_W      = 15,
  parameter int RAM_LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [7:0]        ram_q,
  output logic              ram_wren,
  output logic [7:0]        ram_data,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DL = RAM_LATENCY;
  localparam logic [HW-1:0] HA = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS0 = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS1 = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] HL = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] VA = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS0 = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS1 = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] VL = VW'(V_TOTAL - 1);
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic run, active, hs_raw, vs_raw, h_end, v_end;
  logic [2:0] dly [DL];
  logic [31:0] addr;
  assign ram_wren = 1'b0;
  assign ram_data = 8'h00;
  // run holds the counters at (0,0) for one clock after reset so frame_start lines up with them
  always_comb begin
    active = run && h < HA && v < VA;
    hs_raw = run && h >= HS0 && h < HS1;
    vs_raw = run && v >= VS0 && v < VS1;
    h_end = h == HL;
    v_end = v == VL;
    addr = 32'(v >> SCALE_SHIFT) * 32'(H_ACTIVE >> SCALE_SHIFT) + 32'(h >> SCALE_SHIFT);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      h <= '0;
      v <= '0;
      run <= 1'b0;
      frame_start <= 1'b0;
      ram_address <= '0;
      for (int i = 0; i < DL; i++) dly[i] <= 3'b000;
      vga_r <= 4'h0;
      vga_g <= 4'h0;
      vga_b <= 4'h0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else begin
      run <= 1'b1;
      frame_start <= !run || (h_end && v_end);
      if (run) h <= h_end ? '0 : h + 1'b1;
      if (run && h_end) v <= v_end ? '0 : v + 1'b1;
      ram_address <= active ? ADDR_W'(addr) : '0;
      dly[0] <= {active, hs_raw, vs_raw};
      for (int i = 1; i < DL; i++) dly[i] <= dly[i-1];
      vga_r <= dly[DL-1][2] ? {ram_q[7:5], ram_q[7]} : 4'h0;
      vga_g <= dly[DL-1][2] ? {ram_q[4:2], ram_q[4]} : 4'h0;
      vga_b <= dly[DL-1][2] ? {ram_q[1:0], ram_q[1:0]} : 4'h0;
      vga_hs <= ~dly[DL-1][1];
      vga_vs <= ~dly[DL-1][0];
    end
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed checks of timing, pixel pipeline and reset; vertical geometry shortened to 22 lines so two frames stay short
module tb_vga_scanout;
  logic clock = 1'b0, reset = 1'b1, e3 = 1'b0;
  logic [14:0] ram_address;
  logic [7:0] ram_q = 8'h00, ram_data;
  logic ram_wren, vga_hs, vga_vs, frame_start;
  logic [3:0] vga_r, vga_g, vga_b;
  int n_assert = 0, n_fail = 0, cyc = 0;
  int fs_n, fs_last, fs_prev, hs_low, vs_low, wr_bad, first_low;
  vga_scanout #(.V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut (
    .clock(clock), .reset(reset), .ram_address(ram_address), .ram_q(ram_q),
    .ram_wren(ram_wren), .ram_data(ram_data), .vga_r(vga_r), .vga_g(vga_g),
    .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_start(frame_start)
  );
  always #5 clock = ~clock;
  // port-B model: the registered address plus one output register
  always @(posedge clock) ram_q <= e3 ? 8'hE3 : ram_address[7:0];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic go(input int n);
    while (cyc < n) begin
      @(posedge clock);
      cyc++;
    end
    @(negedge clock);
  endtask
  function automatic logic [11:0] rgb();
    return {vga_r, vga_g, vga_b};
  endfunction
  initial begin
    repeat (3) @(negedge clock);
    chk("rst_rgb", 32'(rgb()), 0);
    chk("rst_hs", 32'(vga_hs), 1);
    chk("rst_vs", 32'(vga_vs), 1);
    chk("rst_fs", 32'(frame_start), 0);
    chk("rst_addr", 32'(ram_address), 0);
    reset = 1'b0;
    cyc = 0;
    go(1); chk("fs_first", 32'(frame_start), 1);
    go(2); chk("fs_drop", 32'(frame_start), 0);
    go(6); chk("addr_4_0", 32'(ram_address), 1);
    go(8); chk("rgb_4_0", 32'(rgb()), 12'h005);
    go(641); chk("addr_639_0", 32'(ram_address), 159);
    go(642); chk("addr_640_0", 32'(ram_address), 0);
    go(643); chk("rgb_639_0", 32'(rgb()), 12'h9FF);
    go(644); chk("rgb_640_0", 32'(rgb()), 0);
    go(659); chk("hs_before", 32'(vga_hs), 1);
    go(660); chk("hs_start", 32'(vga_hs), 0);
    go(755); chk("hs_last", 32'(vga_hs), 0);
    go(756); chk("hs_end", 32'(vga_hs), 1);
    e3 = 1'b1;
    go(1004); chk("rgb_e3", 32'(rgb()), 12'hF0F);
    go(1454); chk("rgb_e3_blank", 32'(rgb()), 0);
    e3 = 1'b0;
    go(3202); chk("addr_0_4", 32'(ram_address), 160);
    go(3204); chk("rgb_0_4", 32'(rgb()), 12'hB00);
    go(12641); chk("addr_last", 32'(ram_address), 639);
    go(12643); chk("rgb_last", 32'(rgb()), 12'h6FF);
    go(12804); chk("rgb_vblank", 32'(rgb()), 0);
    go(14403); chk("vs_before", 32'(vga_vs), 1);
    go(14404); chk("vs_start", 32'(vga_vs), 0);
    go(16003); chk("vs_last", 32'(vga_vs), 0);
    go(16004); chk("vs_end", 32'(vga_vs), 1);
    fs_n = 0; fs_last = 0; fs_prev = 0; hs_low = 0; vs_low = 0; wr_bad = 0;
    while (cyc < 35201) begin
      go(cyc + 1);
      if (frame_start) begin fs_n++; fs_prev = fs_last; fs_last = cyc; end
      if (!vga_hs) hs_low++;
      if (!vga_vs) vs_low++;
      if (ram_wren || ram_data != 0) wr_bad++;
    end
    chk("fs_count", 32'(fs_n), 2);
    chk("fs_last", 32'(fs_last), 35201);
    chk("fs_period", 32'(fs_last - fs_prev), 17600);
    chk("hs_low_clks", 32'(hs_low), 2304);
    chk("vs_low_clks", 32'(vs_low), 1600);
    chk("ram_write", 32'(wr_bad), 0);
    go(43601); chk("pre_rst_rgb", 32'(rgb()), 12'hB0F);
    reset = 1'b1;
    #1;
    chk("mid_rst_rgb", 32'(rgb()), 0);
    chk("mid_rst_addr", 32'(ram_address), 0);
    chk("mid_rst_hs", 32'(vga_hs), 1);
    chk("mid_rst_vs", 32'(vga_vs), 1);
    repeat (5) @(negedge clock);
    chk("mid_rst_fs", 32'(frame_start), 0);
    reset = 1'b0;
    cyc = 0;
    go(1); chk("rst2_fs", 32'(frame_start), 1);
    go(2); chk("rst2_addr", 32'(ram_address), 0);
    hs_low = 0; vs_low = 0; first_low = 0;
    while (cyc < 800) begin
      go(cyc + 1);
      if (!vga_hs && first_low == 0) first_low = cyc;
      if (!vga_hs) hs_low++;
      if (!vga_vs) vs_low++;
    end
    chk("rst2_hs_first", 32'(first_low), 660);
    chk("rst2_hs_width", 32'(hs_low), 96);
    chk("rst2_vs_low", 32'(vs_low), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
